oh_7seg_scan: RTL and testbench
===============================

Name: oh_7seg_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display, and the parametrised successor to the single-digit BCD decoder.
- Holds a double-buffered digit/decimal-point image and scans one digit at a time at a programmable rate.
- Drives shared segment lines plus one-hot anode selects.
- Sits between a register/CSR front end and the board display pins; image updates are tear-free at frame boundaries.

Parameters:
- N, default 4: number of digits, N >= 1.
- DIV, default 1000: clk cycles each digit is lit, DIV >= 1. Prescaler width is max(1, $clog2(DIV)).

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 = display dark.
- load  in  1  one-cycle strobe that captures data/dp/blank into the shadow image.
- data  in  4*N  digit codes; digit i = data[4i+3:4i]; digit 0 is rightmost.
- dp  in  N  decimal point per digit, 1 = lit.
- blank  in  N  per-digit blank, 1 = all segments of that digit off.
- seg  out  7  {a,b,c,d,e,f,g}, a = bit 6, 1 = off.
- dpo  out  1  decimal-point segment, 1 = off.
- an  out  N  anode selects, active-low one-hot, all 1 = dark.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (async on nreset low, released synchronously to clk):
  - seg=7'h7F, dpo=1, an=all 1, frame_done=0.
  - Prescaler=0, digit index=0.
  - Shadow and active images = 0, with all blank bits set.
- Prescaler:
  - Counts 0..DIV-1 while en=1; tick asserts when the count equals DIV-1, and the count then wraps to 0.
  - DIV=1 ticks every cycle.
- Digit index:
  - Advances 0..N-1 on tick and wraps to 0.
  - N=1: the index stays 0 and every tick is a frame wrap.
- Outputs are registered and derived from the active image at the current index; they reflect an index change 1 cycle after the tick.
  - an = ~(1 << idx).
  - seg = decode(active digit[idx]); forced to 7'h7F if active blank[idx] is set.
  - dpo = ~active dp[idx]; also forced to 1 when blanked.
- Decode, 1 = off:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
  - 10..15 decode as 1111111 unless OH_7SEG_HEX_EN is defined.
- Load:
  - load=1 writes the shadow image and sets pending.
  - A later load before the frame wrap overwrites the shadow; the last load wins.
- Frame wrap (tick with idx=N-1):
  - If pending, active <= shadow and pending clears.
  - frame_done pulses on the cycle after the wrap.
  - load coincident with a wrap: active takes the incoming data/dp/blank directly and pending stays 0.
- en=0:
  - Prescaler and index hold; registered outputs go to seg=7'h7F, dpo=1, an=all 1 on the next cycle.
  - load writes shadow and active immediately; no tearing is possible while dark.
  - Re-enabling resumes from the held index and count.
- Reset mid-scan aborts immediately to the reset state and discards pending data.

Optional Feature:
- Macro: OH_7SEG_HEX_EN.
- Defined: codes 10..15 decode as A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Undefined: codes 10..15 decode as blank (1111111), matching BCD-only behaviour.

Test Plan:
- Reset with N=4, DIV=4: hold nreset low for 3 cycles -> seg=7'h7F, dpo=1, an=4'b1111, frame_done=0. Also assert nreset asynchronously mid-cycle -> outputs reach reset values without a clk edge.
- Scan order, N=4, DIV=4, en=1: load data=16'h1234, dp=4'b0010, blank=0.
  - After the next frame wrap: an=1110 with seg=1001100 for 4 cycles, then an=1101 with seg=0000110 and dpo=0, then an=1011 with seg=0010010, then an=0111 with seg=1001111.
  - frame_done pulses once per 16 cycles.
- Tear-free update: load 16'h5555 while idx=1 -> remaining digits of the current frame still show the old image; the new image first appears at idx=0 after frame_done. Load coincident with the wrap -> new data shows on idx 0 of the very next frame.
- Blank and disable:
  - blank=4'b1000 -> digit 3 slot drives an=0111 with seg=7'h7F, dpo=1.
  - en=0 mid-frame -> an=1111 on the next cycle; re-enable resumes from the held idx.
  - load with en=0 -> active image updates immediately.
- Hex option: data digit=4'hA -> seg=0001000 with OH_7SEG_HEX_EN defined, 1111111 without it; 4'hF -> 0111000 / 1111111.
- Edge parameters: N=1, DIV=1 -> an=0 constantly, frame_done every cycle, loaded value visible 2 cycles after load.

Source files
------------

// File: rtl/oh_7seg_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a tear-free double-buffered image.
// Define OH_7SEG_HEX_EN to decode codes 10..15 as A,b,C,d,E,F instead of blank.
module oh_7seg_scan #(
  parameter int N   = 4,
  parameter int DIV = 1000
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           en,
  input  logic           load,
  input  logic [4*N-1:0] data,
  input  logic [N-1:0]   dp,
  input  logic [N-1:0]   blank,
  output logic [6:0]     seg,
  output logic           dpo,
  output logic [N-1:0]   an,
  output logic           frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(N - 1);

  typedef struct packed {
    logic [N-1:0][3:0] dig;
    logic [N-1:0]      dp;
    logic [N-1:0]      blank;
  } img_t;

  localparam img_t IMG_RST = img_t'({{(5*N){1'b0}}, {N{1'b1}}});

  img_t          shadow, active, din;
  logic          pend;
  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  logic          tick, wrap;
  logic [3:0]    cur_dig;
  logic          cur_dp, cur_bl;
  logic [N-1:0]  an_nx;

  assign din  = {data, dp, blank};
  assign tick = en && (pcnt == PMAX);
  assign wrap = tick && (idx == IMAX);

  function automatic logic [6:0] dec7(input logic [3:0] c);
    case (c)
      4'h0: dec7 = 7'b0000001;
      4'h1: dec7 = 7'b1001111;
      4'h2: dec7 = 7'b0010010;
      4'h3: dec7 = 7'b0000110;
      4'h4: dec7 = 7'b1001100;
      4'h5: dec7 = 7'b0100100;
      4'h6: dec7 = 7'b0100000;
      4'h7: dec7 = 7'b0001111;
      4'h8: dec7 = 7'b0000000;
      4'h9: dec7 = 7'b0001100;
`ifdef OH_7SEG_HEX_EN
      4'hA: dec7 = 7'b0001000;
      4'hB: dec7 = 7'b1100000;
      4'hC: dec7 = 7'b0110001;
      4'hD: dec7 = 7'b1000010;
      4'hE: dec7 = 7'b0110000;
      4'hF: dec7 = 7'b0111000;
`endif
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= (idx == IMAX) ? '0 : idx + IW'(1);
    end else if (en) begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Dark or wrapping: nothing visible can tear, so the load goes straight to active.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shadow <= IMG_RST;
      active <= IMG_RST;
      pend   <= 1'b0;
    end else if (load && (!en || wrap)) begin
      shadow <= din;
      active <= din;
      pend   <= 1'b0;
    end else if (load) begin
      shadow <= din;
      pend   <= 1'b1;
    end else if (wrap && pend) begin
      active <= shadow;
      pend   <= 1'b0;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_an
    assign an_nx[g] = (idx != IW'(g));
  end

  always_comb begin
    cur_dig = '0;
    cur_dp  = 1'b0;
    cur_bl  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        cur_dig = active.dig[i];
        cur_dp  = active.dp[i];
        cur_bl  = active.blank[i];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seg        <= 7'h7F;
      dpo        <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (!en) begin
        seg <= 7'h7F;
        dpo <= 1'b1;
        an  <= '1;
      end else begin
        seg <= cur_bl ? 7'h7F : dec7(cur_dig);
        dpo <= cur_bl | ~cur_dp;
        an  <= an_nx;
      end
    end
  end

endmodule

// File: tb/tb_oh_7seg_scan.sv
// Scoreboard bench for oh_7seg_scan: N=4/DIV=4 main instance plus an N=1/DIV=1 edge instance.
module tb_oh_7seg_scan;

  typedef struct {
    int          u;
    int          nc;
    logic [12:0] exp;
    string       nm;
  } sb_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        en = 1'b0, load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0, blank = '0;
  logic [6:0]  seg;
  logic        dpo, fd;
  logic [3:0]  an;

  logic        en1 = 1'b0, load1 = 1'b0;
  logic [3:0]  data1 = '0;
  logic        dp1 = 1'b0, blank1 = 1'b0;
  logic [6:0]  seg1;
  logic        dpo1, fd1;
  logic        an1;

  sb_t         sbq[$];
  int          nc = 0;
  int          base = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [6:0]  dec [16];

  oh_7seg_scan #(.N(4), .DIV(4)) dut (
    .clk(clk), .nreset(nreset), .en(en), .load(load), .data(data), .dp(dp),
    .blank(blank), .seg(seg), .dpo(dpo), .an(an), .frame_done(fd));

  oh_7seg_scan #(.N(1), .DIV(1)) dut1 (
    .clk(clk), .nreset(nreset), .en(en1), .load(load1), .data(data1), .dp(dp1),
    .blank(blank1), .seg(seg1), .dpo(dpo1), .an(an1), .frame_done(fd1));

  always #5 clk = ~clk;

  initial begin
    dec[0] = 7'b0000001; dec[1] = 7'b1001111; dec[2] = 7'b0010010; dec[3] = 7'b0000110;
    dec[4] = 7'b1001100; dec[5] = 7'b0100100; dec[6] = 7'b0100000; dec[7] = 7'b0001111;
    dec[8] = 7'b0000000; dec[9] = 7'b0001100;
`ifdef OH_7SEG_HEX_EN
    dec[10] = 7'b0001000; dec[11] = 7'b1100000; dec[12] = 7'b0110001;
    dec[13] = 7'b1000010; dec[14] = 7'b0110000; dec[15] = 7'b0111000;
`else
    for (int i = 10; i < 16; i++) dec[i] = 7'b1111111;
`endif
  end

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got seg/dpo/an/fd=%b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: every negedge, compare the outputs against entries due at this sample.
  always @(negedge clk) begin
    nc++;
    while (sbq.size() > 0 && sbq[0].nc <= nc) begin
      sb_t e;
      e = sbq.pop_front();
      if (e.nc < nc) chk({e.nm, "_stale"}, 13'h0, 13'h1FFF);
      else if (e.u == 0) chk(e.nm, {seg, dpo, an, fd}, e.exp);
      else chk(e.nm, {seg1, dpo1, 3'b000, an1, fd1}, e.exp);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_raw(input int u, input int k, input logic [6:0] s, input logic d,
                          input logic [3:0] a, input logic f, input string nm);
    sb_t e;
    e.u = u; e.nc = base + k; e.exp = {s, d, a, f}; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic pushd(input int k, input int i, input logic [3:0] code, input logic dpb,
                       input logic blb, input logic f, input string nm);
    logic [3:0] a;
    a = ~(4'b0001 << i);
    push_raw(0, k, blb ? 7'h7F : dec[code], blb | ~dpb, a, f, nm);
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int i);
    return v[4*i +: 4];
  endfunction

  initial begin
    logic [15:0] v;
    logic [3:0]  m, bl;
    int          i;

    // Reset held for 3 cycles
    step(3);
    base = nc;
    push_raw(0, 1, 7'h7F, 1'b1, 4'b1111, 1'b0, "reset_main");
    push_raw(1, 1, 7'h7F, 1'b1, 4'b0001, 1'b0, "reset_n1");
    step(1);
    nreset = 1'b1;
    step(1);

    // Scan order: first frame still shows the blank reset image, then 1234
    base = nc; v = 16'h1234; m = 4'b0010;
    en = 1'b1; load = 1'b1; data = v; dp = m; blank = 4'b0000;
    for (int k = 1; k <= 36; k++) begin
      i = ((k - 1) / 4) % 4;
      if (k <= 16) pushd(k, i, 4'h0, 1'b0, 1'b1, k == 16, "scan_pre");
      else         pushd(k, i, nib(v, i), m[i], 1'b0, k == 32, "scan_1234");
    end
    step(1); load = 1'b0;
    step(35);

    // Tear-free: load 5555 at idx=1, old image finishes the frame
    base = nc;
    load = 1'b1; data = 16'h5555; dp = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      i = (1 + (k - 1) / 4) % 4;
      if (k <= 12) pushd(k, i, nib(v, i), m[i], 1'b0, k == 12, "tear_old");
      else         pushd(k, i, 4'h5, 1'b0, 1'b0, 1'b0, "tear_new");
    end
    step(1); load = 1'b0;
    step(15);

    // Load coincident with the wrap goes straight to the next frame
    base = nc;
    for (int k = 1; k <= 20; k++) begin
      i = (1 + (k - 1) / 4) % 4;
      if (k <= 12) pushd(k, i, 4'h5, 1'b0, 1'b0, k == 12, "wrapld_old");
      else         pushd(k, i, nib(16'h6789, i), k <= 16, 1'b0, 1'b0, "wrapld_new");
    end
    step(11);
    load = 1'b1; data = 16'h6789; dp = 4'b0001;
    step(1); load = 1'b0;
    step(8);

    // Disable mid-frame with an immediate load, then resume at the held idx=2
    base = nc; v = 16'h3456; m = 4'b0100; bl = 4'b1000;
    en = 1'b0; load = 1'b1; data = v; dp = m; blank = bl;
    push_raw(0, 1, 7'h7F, 1'b1, 4'b1111, 1'b0, "dis_dark");
    push_raw(0, 2, 7'h7F, 1'b1, 4'b1111, 1'b0, "dis_dark");
    for (int k = 3; k <= 14; k++) begin
      i = (2 + (k - 3) / 4) % 4;
      pushd(k, i, nib(v, i), m[i], bl[i], k == 10, "resume");
    end
    step(1); load = 1'b0;
    step(1); en = 1'b1;
    step(12);

    // Hex codes: digit0=A, digit1=F; resumes at idx=1
    base = nc; v = 16'h00FA;
    en = 1'b0; load = 1'b1; data = v; dp = 4'b0000; blank = 4'b0000;
    push_raw(0, 1, 7'h7F, 1'b1, 4'b1111, 1'b0, "hex_dark");
    for (int k = 2; k <= 17; k++) begin
      i = (1 + (k - 2) / 4) % 4;
      pushd(k, i, nib(v, i), 1'b0, 1'b0, k == 13, "hex");
    end
    step(1); load = 1'b0; en = 1'b1;
    step(16);

    // Async reset lands between clock edges
    #2 nreset = 1'b0;
    #1 chk("async_reset", {seg, dpo, an, fd}, {7'h7F, 1'b1, 4'b1111, 1'b0});
    en = 1'b0;
    step(2);
    nreset = 1'b1;
    step(1);

    // N=1, DIV=1: every cycle is a wrap, load visible two cycles later
    base = nc;
    en1 = 1'b1; load1 = 1'b1; data1 = 4'h7; dp1 = 1'b1; blank1 = 1'b0;
    push_raw(1, 1, 7'h7F, 1'b1, 4'b0000, 1'b1, "n1_first");
    push_raw(1, 2, dec[7], 1'b0, 4'b0000, 1'b1, "n1_7");
    push_raw(1, 3, dec[7], 1'b0, 4'b0000, 1'b1, "n1_7");
    push_raw(1, 4, dec[7], 1'b0, 4'b0000, 1'b1, "n1_7_hold");
    push_raw(1, 5, dec[2], 1'b1, 4'b0000, 1'b1, "n1_2");
    push_raw(1, 6, dec[2], 1'b1, 4'b0000, 1'b1, "n1_2");
    step(1); load1 = 1'b0;
    step(2); load1 = 1'b1; data1 = 4'h2; dp1 = 1'b0;
    step(1); load1 = 1'b0;
    step(4);

    if (sbq.size() != 0) chk("sb_drain", 13'(sbq.size()), 13'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
